// File: rtl/sudoku_grid_reader_if.sv
// sudoku_grid_reader_if
// Bundles the solver display-side signals and the board status signals that
// pass through the grid reader.
//   Start       : one-cycle scan request from the board
//   Disp        : solver reports it is showing a finished grid
//   SolverRow   : solver current row (0..8)
//   SolverCol   : solver current column (0..8)
//   SolverValue : solver digit at the current cell (raw 4-bit value)
//   NextOut     : one-cycle step pulse back to the solver Next input
//   Busy        : scan in progress
//   Done        : scan finished, held until the next accepted Start
//   Valid       : grid is a legal solution (meaningful with Done)
//   ErrCode     : 0 none, 1 bad digit, 2 duplicate, 3 sequence error
//   ErrRow      : row of first offending cell
//   ErrCol      : column of first offending cell
// Modports:
//   master : solver/board side (drives Start, Disp and the solver cell bus)
//   slave  : grid reader side
interface sudoku_grid_reader_if;
  logic       Start;
  logic       Disp;
  logic [3:0] SolverRow;
  logic [3:0] SolverCol;
  logic [3:0] SolverValue;
  logic       NextOut;
  logic       Busy;
  logic       Done;
  logic       Valid;
  logic [1:0] ErrCode;
  logic [3:0] ErrRow;
  logic [3:0] ErrCol;

  modport master (
    output Start, Disp, SolverRow, SolverCol, SolverValue,
    input  NextOut, Busy, Done, Valid, ErrCode, ErrRow, ErrCol
  );

  modport slave (
    input  Start, Disp, SolverRow, SolverCol, SolverValue,
    output NextOut, Busy, Done, Valid, ErrCode, ErrRow, ErrCol
  );
endinterface

// File: rtl/sudoku_grid_reader.sv
// sudoku_grid_reader
// Walks a finished grid out of the solver display port one cell at a time
// (row-major, (0,0) to (8,8)) and checks that it is a legal solved Sudoku:
// every digit in 1..9 and no repeat in any row, column or 3x3 box. Reports
// pass/fail plus the first offending cell.
// Ports:
//   Clk   : system clock
//   Reset : asynchronous, active-high reset; aborts any scan in progress
//   bus   : sudoku_grid_reader_if.slave (Start/Disp/solver cell bus in,
//           NextOut/Busy/Done/Valid/ErrCode/ErrRow/ErrCol out)
// Parameters:
//   SETTLE_CYCLES : cycles to wait after Start / each Next pulse before the
//                   solver outputs are sampled (1..255)
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for Start with Disp=1
// S_SETTLE  | counting down SETTLE_CYCLES for solver outputs to settle
// S_CHECK   | one cycle: check position, digit range and duplicates
// S_ADVANCE | one cycle: pulse NextOut and step the expected position
// S_DONE    | result held until a new Start with Disp=1
module sudoku_grid_reader #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                  Clk,
  input logic                  Reset,
  sudoku_grid_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DIGIT = 2'd1;
  localparam logic [1:0] ERR_DUP   = 2'd2;
  localparam logic [1:0] ERR_SEQ   = 2'd3;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;

  logic [8:0] row_mask [0:8];
  logic [8:0] col_mask [0:8];
  logic [8:0] box_mask [0:8];

  logic [3:0] exp_r, exp_c;
  logic [7:0] settle_cnt;

  logic       valid_q;
  logic [1:0] err_code_q;
  logic [3:0] err_row_q, err_col_q;

  // Cell decode for the current expected position and sampled digit
  logic [1:0] r_band, c_band;
  logic [3:0] box_idx;
  logic       digit_ok;
  logic [8:0] digit_oh;
  logic       pos_ok;
  logic       dup_hit;
  logic       last_cell;

  // Control strobes from the next-state logic
  logic       start_scan;
  logic       load_settle;
  logic       commit;
  logic       fail;
  logic [1:0] fail_code;
  logic       finish_ok;
  logic       step_pos;

  // Box index = 3*(row band) + (column band), bands found by compares
  always_comb begin
    r_band = 2'd0;
    c_band = 2'd0;
    if (exp_r < 4'd3)      r_band = 2'd0;
    else if (exp_r < 4'd6) r_band = 2'd1;
    else                   r_band = 2'd2;
    if (exp_c < 4'd3)      c_band = 2'd0;
    else if (exp_c < 4'd6) c_band = 2'd1;
    else                   c_band = 2'd2;
    box_idx = {1'b0, r_band, 1'b0} + {2'b00, r_band} + {2'b00, c_band};
  end

  always_comb begin
    digit_ok = (bus.SolverValue >= 4'd1) && (bus.SolverValue <= 4'd9);
    digit_oh = 9'd0;
    if (digit_ok) digit_oh = 9'd1 << (bus.SolverValue - 4'd1);
  end

  assign pos_ok    = bus.Disp && (bus.SolverRow == exp_r) && (bus.SolverCol == exp_c);
  assign dup_hit   = |(digit_oh & (row_mask[exp_r] | col_mask[exp_c] | box_mask[box_idx]));
  assign last_cell = (exp_r == 4'd8) && (exp_c == 4'd8);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_scan  = 1'b0;
    load_settle = 1'b0;
    commit      = 1'b0;
    fail        = 1'b0;
    fail_code   = ERR_NONE;
    finish_ok   = 1'b0;
    step_pos    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.Start && bus.Disp) begin
          start_scan  = 1'b1;
          load_settle = 1'b1;
          state_nxt   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == 8'd0) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // Priority: sequence, digit range, duplicate
        if (!pos_ok) begin
          fail      = 1'b1;
          fail_code = ERR_SEQ;
          state_nxt = S_DONE;
        end else if (!digit_ok) begin
          fail      = 1'b1;
          fail_code = ERR_DIGIT;
          state_nxt = S_DONE;
        end else if (dup_hit) begin
          fail      = 1'b1;
          fail_code = ERR_DUP;
          state_nxt = S_DONE;
        end else begin
          commit = 1'b1;
          if (last_cell) begin
            finish_ok = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        step_pos    = 1'b1;
        load_settle = 1'b1;
        state_nxt   = S_SETTLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Settle timer: loaded with SETTLE_CYCLES-1, CHECK follows terminal count
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      settle_cnt <= 8'd0;
    end else if (load_settle) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == S_SETTLE) && (settle_cnt != 8'd0)) begin
      settle_cnt <= settle_cnt - 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      exp_r <= 4'd0;
      exp_c <= 4'd0;
    end else if (start_scan) begin
      exp_r <= 4'd0;
      exp_c <= 4'd0;
    end else if (step_pos) begin
      if (exp_c == 4'd8) begin
        exp_c <= 4'd0;
        exp_r <= exp_r + 4'd1;
      end else begin
        exp_c <= exp_c + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 9; i++) begin
        row_mask[i] <= 9'd0;
        col_mask[i] <= 9'd0;
        box_mask[i] <= 9'd0;
      end
    end else if (start_scan) begin
      for (int i = 0; i < 9; i++) begin
        row_mask[i] <= 9'd0;
        col_mask[i] <= 9'd0;
        box_mask[i] <= 9'd0;
      end
    end else if (commit) begin
      row_mask[exp_r]   <= row_mask[exp_r]   | digit_oh;
      col_mask[exp_c]   <= col_mask[exp_c]   | digit_oh;
      box_mask[box_idx] <= box_mask[box_idx] | digit_oh;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      err_row_q  <= 4'd0;
      err_col_q  <= 4'd0;
    end else if (start_scan) begin
      valid_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      err_row_q  <= 4'd0;
      err_col_q  <= 4'd0;
    end else if (fail) begin
      valid_q    <= 1'b0;
      err_code_q <= fail_code;
      err_row_q  <= exp_r;
      err_col_q  <= exp_c;
    end else if (finish_ok) begin
      valid_q    <= 1'b1;
      err_code_q <= ERR_NONE;
    end
  end

  // Status outputs decode straight from the state register so Reset clears
  // them, and NextOut, without waiting for a clock edge.
  assign bus.NextOut = (state == S_ADVANCE);
  assign bus.Busy    = (state == S_SETTLE) || (state == S_CHECK) || (state == S_ADVANCE);
  assign bus.Done    = (state == S_DONE);
  assign bus.Valid   = valid_q;
  assign bus.ErrCode = err_code_q;
  assign bus.ErrRow  = err_row_q;
  assign bus.ErrCol  = err_col_q;

endmodule

// File: tb/tb_sudoku_grid_reader.sv
// tb_sudoku_grid_reader
// Drives a simple solver model (a 81-entry grid stepped by NextOut) into
// sudoku_grid_reader and checks result, first-error cell, Done timing,
// NextOut pulse count and Busy shape against hand-computed vectors.
module tb_sudoku_grid_reader;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  sudoku_grid_reader_if bus ();

  sudoku_grid_reader #(.SETTLE_CYCLES(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int mod_idx;
    int mod_val;
    int ignore_at;
    int drop_at;
    int start2_edge;
    int exp_valid;
    int exp_err;
    int exp_row;
    int exp_col;
    int exp_pulses;
    int exp_done;
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] grid [81];
  int         pos;
  int         ignore_at;
  int         drop_at;
  int         pulse_cnt;
  int         n_cmp;
  int         n_bad;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Known-legal pattern: value = ((3r + r/3 + c) mod 9) + 1
  task automatic fill_good();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        grid[r*9 + c] = 4'(((r*3 + r/3 + c) % 9) + 1);
  endtask

  task automatic set_solver();
    bus.SolverRow   = 4'(pos / 9);
    bus.SolverCol   = 4'(pos % 9);
    bus.SolverValue = grid[pos];
  endtask

  // One clock: note NextOut during the cycle, then let the model react #1
  // after the edge, as a solver stepping on Next would.
  task automatic step();
    logic saw;
    saw = bus.NextOut;
    @(posedge Clk);
    #1;
    if (saw) begin
      pulse_cnt++;
      if (pos != ignore_at && pos < 80) pos++;
      if (pos == drop_at) bus.Disp = 1'b0;
      set_solver();
    end
  endtask

  task automatic run_scan(input vec_t v, output int done_edge, output int busy_bad);
    int edge_n;
    fill_good();
    if (v.mod_idx >= 0) grid[v.mod_idx] = 4'(v.mod_val);
    ignore_at = v.ignore_at;
    drop_at   = v.drop_at;
    pos       = 0;
    bus.Disp  = 1'b1;
    set_solver();
    pulse_cnt = 0;
    busy_bad  = 0;
    done_edge = -1;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    edge_n = 0;
    if (!bus.Busy || bus.Done) busy_bad++;
    while (edge_n < 400 && done_edge < 0) begin
      if (edge_n + 1 == v.start2_edge) bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      edge_n++;
      if (bus.Done) begin
        done_edge = edge_n;
        if (bus.Busy) busy_bad++;
      end else if (!bus.Busy) begin
        busy_bad++;
      end
    end
  endtask

  initial begin
    int done_edge;
    int busy_bad;
    int busy_seen;
    int budget;

    n_cmp = 0;
    n_bad = 0;
    ignore_at = -1;
    drop_at   = -1;
    pos       = 0;
    pulse_cnt = 0;
    bus.Start = 1'b0;
    bus.Disp  = 1'b0;
    fill_good();
    set_solver();

    //            idx val ign drop st2 | val err row col pulses done
    vecs[0] = '{-1,  0, -1, -1,  5,    1,  0,  0,  0,  80,  323};
    vecs[1] = '{43,  5, -1, -1, -1,    0,  2,  4,  7,  43,  175};
    vecs[2] = '{ 0,  0, -1, -1, -1,    0,  1,  0,  0,   0,    3};
    vecs[3] = '{ 0, 10, -1, -1, -1,    0,  1,  0,  0,   0,    3};
    vecs[4] = '{-1,  0, 21, -1, -1,    0,  3,  2,  4,  22,   91};
    vecs[5] = '{-1,  0, -1, 55, -1,    0,  3,  6,  1,  55,  223};
    vecs[6] = '{-1,  0, -1, -1, -1,    1,  0,  0,  0,  80,  323};

    repeat (3) @(posedge Clk);
    #1;
    check("reset.Busy",    bus.Busy,    0);
    check("reset.Done",    bus.Done,    0);
    check("reset.Valid",   bus.Valid,   0);
    check("reset.ErrCode", bus.ErrCode, 0);
    check("reset.ErrRow",  bus.ErrRow,  0);
    check("reset.ErrCol",  bus.ErrCol,  0);
    check("reset.NextOut", bus.NextOut, 0);
    Reset = 1'b0;

    // Start with Disp=0 in IDLE is ignored
    bus.Disp  = 1'b0;
    pulse_cnt = 0;
    busy_seen = 0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Busy || bus.Done) busy_seen++;
      step();
    end
    check("nodisp.busy_or_done", busy_seen, 0);
    check("nodisp.pulses",       pulse_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      run_scan(vecs[i], done_edge, busy_bad);
      check($sformatf("v%0d.done_edge", i), done_edge,   vecs[i].exp_done);
      check($sformatf("v%0d.pulses", i),    pulse_cnt,   vecs[i].exp_pulses);
      check($sformatf("v%0d.Valid", i),     bus.Valid,   vecs[i].exp_valid);
      check($sformatf("v%0d.ErrCode", i),   bus.ErrCode, vecs[i].exp_err);
      check($sformatf("v%0d.ErrRow", i),    bus.ErrRow,  vecs[i].exp_row);
      check($sformatf("v%0d.ErrCol", i),    bus.ErrCol,  vecs[i].exp_col);
      check($sformatf("v%0d.busy_shape", i), busy_bad,   0);
    end

    // Reset after 10 cells aborts the scan with no further NextOut
    fill_good();
    ignore_at = -1;
    drop_at   = -1;
    pos       = 0;
    bus.Disp  = 1'b1;
    set_solver();
    pulse_cnt = 0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    budget = 0;
    while (pos < 10 && budget < 200) begin
      step();
      budget++;
    end
    check("abort.cells_reached", pos, 10);
    check("abort.busy_before", bus.Busy, 1);
    Reset = 1'b1;
    #1;
    check("abort.Busy",    bus.Busy,    0);
    check("abort.Done",    bus.Done,    0);
    check("abort.NextOut", bus.NextOut, 0);
    check("abort.Valid",   bus.Valid,   0);
    check("abort.ErrCode", bus.ErrCode, 0);
    pulse_cnt = 0;
    busy_seen = 0;
    repeat (3) step();
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Busy || bus.Done) busy_seen++;
      step();
    end
    check("abort.pulses_after", pulse_cnt, 0);
    check("abort.idle_after",   busy_seen, 0);

    // Clean scan after the abort
    run_scan(vecs[6], done_edge, busy_bad);
    check("rescan.done_edge", done_edge, 323);
    check("rescan.pulses",    pulse_cnt, 80);
    check("rescan.Valid",     bus.Valid, 1);
    check("rescan.ErrCode",   bus.ErrCode, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
